ones_pattern_gen: RTL
=====================

ONES_PATTERN_GEN -- requirements
Module: ones_pattern_gen

Interface
REQ-001 Parameter: FRAME, default 9, frame length in bits; legal range 1..15.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request to transmit one frame; sampled on the rising edge of clk.
REQ-005 count  input  4  requested number of ones in the frame.
REQ-006 ready  output  1  high when the block can accept start.
REQ-007 ser_out  output  1  serial frame bit, LSB first.
REQ-008 ser_valid  output  1  high while ser_out carries a frame bit.
REQ-009 frame_done  output  1  one-cycle pulse after the last frame bit.
REQ-010 therm  output  FRAME  parallel thermometer code of the accepted count.
REQ-011 err  output  1  high when the accepted count exceeded FRAME.

Function
REQ-012 The block SHALL be the inverse of a ones counter: it generates a FRAME-bit pattern containing exactly n ones, where n is the accepted count.
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE, encoded in registers.
REQ-014 Handshake: a start is accepted only on an edge where start=1 and ready=1; ready SHALL be 1 only in IDLE.
REQ-015 Accepted count n SHALL be computed as min(count, FRAME), captured on the accept edge; count SHALL NOT be sampled again during the frame.
REQ-016 On accept, therm SHALL load ((1<<n)-1), i.e. bit i = 1 iff i < n; therm SHALL hold until the next accept.
REQ-017 On accept, err SHALL load (count > FRAME); err SHALL hold until the next accept.
REQ-018 IDLE->SHIFT on accept; the first frame bit SHALL appear on the cycle after accept (latency 1).
REQ-019 In SHIFT, a 4-bit bit index i SHALL run 0..FRAME-1, one bit per cycle, with ser_valid=1 and ser_out=(i < n).
REQ-020 SHIFT->DONE after bit index FRAME-1 has been driven; ser_valid SHALL be 0 in DONE.
REQ-021 DONE SHALL last exactly one cycle with frame_done=1, then go to IDLE.
REQ-022 Accept-to-next-accept minimum spacing SHALL be FRAME+2 cycles.
REQ-023 start while ready=0 SHALL be ignored, with no queuing and no effect on the current frame.
REQ-024 Outside SHIFT, ser_out SHALL be 0.
REQ-025 n=0 SHALL produce FRAME zero bits with ser_valid high, plus frame_done; n=FRAME SHALL produce all ones.
REQ-026 start held high continuously SHALL cause back-to-back frames, each re-sampling count on its accept edge.

Reset
REQ-027 While rst_n=0, outputs SHALL be forced asynchronously to: state=IDLE, ready=1, ser_out=0, ser_valid=0, frame_done=0, therm=0, err=0, bit index=0.
REQ-028 Reset mid-frame SHALL abort the frame immediately, without a frame_done pulse.
REQ-029 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-030 Directed scenario: count=5, start pulse -> therm=9'b000011111, err=0; ser_out 1,1,1,1,1,0,0,0,0 on cycles 1..9 with ser_valid=1; frame_done on cycle 10; ready=1 on cycle 11.
REQ-031 Directed scenario: count=0 -> nine 0 bits with ser_valid=1, therm=0, frame_done pulse; then count=9 -> nine 1 bits, therm=9'h1FF.
REQ-032 Directed scenario: count=13 -> err=1, therm=9'h1FF, nine 1 bits; a following count=2 -> err returns to 0.
REQ-033 Directed scenario: start and count=3 pulsed during SHIFT of a count=7 frame -> the 7-ones frame completes unchanged and no second frame starts.
REQ-034 Directed scenario: rst_n low at bit index 4 -> ser_valid, ser_out and therm go to 0 immediately, no frame_done, ready=1.
REQ-035 Self-check: for every frame, the sum of ser_out over ser_valid cycles SHALL equal n and SHALL match the ones count of therm, for all count values 0..15.

Source files
------------

// File: rtl/ones_pattern_gen.sv
// Serial frame generator producing FRAME bits with exactly n ones (LSB first),
// plus a parallel thermometer code of the accepted count.
module ones_pattern_gen #(
  parameter int FRAME = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       count,
  output logic             ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done,
  output logic [FRAME-1:0] therm,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] FRAME_N = 4'(FRAME);
  localparam logic [3:0] LAST_IDX = 4'(FRAME - 1);

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       n_q, n_d;
  logic [FRAME-1:0] therm_q, therm_d;
  logic             err_q, err_d;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    therm_d = therm_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d   = (count > FRAME_N) ? FRAME_N : count;
          err_d = (count > FRAME_N);
          for (int i = 0; i < FRAME; i++) begin
            therm_d[i] = (4'(i) < n_d);
          end
          idx_d   = 4'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = 4'd0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      n_q     <= 4'd0;
      therm_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      therm_q <= therm_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode registered state only, so reset forces them immediately.
  always_comb begin
    ready      = (state_q == IDLE);
    ser_valid  = (state_q == SHIFT);
    ser_out    = (state_q == SHIFT) && (idx_q < n_q);
    frame_done = (state_q == DONE);
    therm      = therm_q;
    err        = err_q;
  end

endmodule
